ff_stuff_ctrl: RTL and testbench

//  Read-side sequencer for the 32-bit entropy-coded word FIFO (sync_fifo_32 class).
//  - Issues read requests and captures returned words.
//  - Serialises each word MSB byte first onto a byte stream.
//  - Inserts 0x00 after every 0xFF data byte (JPEG byte stuffing).
//  - On request, appends the EOI marker FF D9 once all data has drained.
//  - Sits between the FIFO and the output byte sink/bitstream writer.

---
 rtl/ff_stuff_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_ff_stuff_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ff_stuff_ctrl.sv
// Read-side sequencer: pulls 32-bit words from the entropy FIFO and emits them MSB byte first,
// inserting 0x00 after 0xFF data bytes, with an optional trailing FF D9 EOI marker.
`timescale 1ns/1ps
module ff_stuff_ctrl #(
    parameter bit STUFF_EN = 1'b1,
    parameter bit PREFETCH = 1'b1,
    parameter int CNT_W    = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    output logic             read_req,
    input  logic [31:0]      read_data,
    input  logic             rdata_valid,
    output logic [7:0]       out_byte,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             eoi_req,
    output logic             eoi_done,
    output logic             busy,
    output logic [CNT_W-1:0] byte_count
);

    typedef enum logic [2:0] {IDLE, EMIT, STUFF, EOI_FF, EOI_D9} state_t;

    state_t             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [31:0]        hold_q, hold_d;
    logic               hold_vld_q, hold_vld_d;
    logic [31:0]        nxt_q, nxt_d;
    logic               nxt_vld_q, nxt_vld_d;
    logic               outst_q, outst_d;
    logic               eoi_pend_q, eoi_pend_d;
    logic               eoi_done_q, eoi_done_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [7:0] cur_byte;
    logic       accept, stuff_now, capture, slot_free, eoi_blk, word_done;

    always_comb begin
        case (idx_q)
            2'd0:    cur_byte = hold_q[31:24];
            2'd1:    cur_byte = hold_q[23:16];
            2'd2:    cur_byte = hold_q[15:8];
            default: cur_byte = hold_q[7:0];
        endcase
    end

    always_comb begin
        out_valid = (state_q != IDLE);
        case (state_q)
            EMIT:    out_byte = cur_byte;
            EOI_FF:  out_byte = 8'hFF;
            EOI_D9:  out_byte = 8'hD9;
            default: out_byte = 8'h00;
        endcase
    end

    assign accept    = out_valid && out_ready;
    assign stuff_now = STUFF_EN && (cur_byte == 8'hFF);
    assign capture   = rdata_valid && outst_q;
    // Reads stay frozen from the start of the marker until eoi_done has been seen.
    assign eoi_blk   = (state_q == EOI_FF) || (state_q == EOI_D9) || eoi_done_q;
    assign slot_free = PREFETCH ? (!hold_vld_q || !nxt_vld_q)
                                : (state_q == IDLE && !hold_vld_q);
    assign read_req  = !rst && !fifo_empty && !outst_q && slot_free && !eoi_blk;

    assign eoi_done   = eoi_done_q;
    assign byte_count = cnt_q;
    assign busy       = !(state_q == IDLE && !hold_vld_q && !nxt_vld_q && !outst_q);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        nxt_d      = nxt_q;
        nxt_vld_d  = nxt_vld_q;
        outst_d    = outst_q;
        eoi_pend_d = eoi_pend_q;
        eoi_done_d = 1'b0;
        cnt_d      = cnt_q;
        word_done  = 1'b0;

        if (eoi_req) eoi_pend_d = 1'b1;
        if (accept)  cnt_d = cnt_q + CNT_W'(1);

        case (state_q)
            IDLE: begin
                if (hold_vld_q) begin
                    state_d = EMIT;
                    idx_d   = 2'd0;
                end else if (eoi_pend_q && fifo_empty && !outst_q && !nxt_vld_q) begin
                    state_d = EOI_FF;
                end
            end
            EMIT: begin
                if (accept) begin
                    if (stuff_now)           state_d = STUFF;
                    else if (idx_q != 2'd3)  idx_d = idx_q + 2'd1;
                    else                     word_done = 1'b1;
                end
            end
            STUFF: begin
                if (accept) begin
                    if (idx_q != 2'd3) begin
                        state_d = EMIT;
                        idx_d   = idx_q + 2'd1;
                    end else begin
                        word_done = 1'b1;
                    end
                end
            end
            EOI_FF: if (accept) state_d = EOI_D9;
            EOI_D9: begin
                if (accept) begin
                    state_d    = IDLE;
                    eoi_done_d = 1'b1;
                    eoi_pend_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (word_done) begin
            idx_d = 2'd0;
            if (nxt_vld_q) begin
                hold_d     = nxt_q;
                hold_vld_d = 1'b1;
                nxt_vld_d  = 1'b0;
                state_d    = EMIT;
            end else begin
                hold_vld_d = 1'b0;
                state_d    = IDLE;
            end
        end

        // A returning word goes straight to emission when the hold slot is free,
        // which is what gives the two-cycle read_req to out_valid latency.
        if (capture) begin
            outst_d = 1'b0;
            if (!hold_vld_d && state_d == IDLE) begin
                hold_d     = read_data;
                hold_vld_d = 1'b1;
                state_d    = EMIT;
                idx_d      = 2'd0;
            end else if (!nxt_vld_d) begin
                nxt_d     = read_data;
                nxt_vld_d = 1'b1;
            end
        end

        if (read_req) outst_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            hold_q     <= 32'd0;
            hold_vld_q <= 1'b0;
            nxt_q      <= 32'd0;
            nxt_vld_q  <= 1'b0;
            outst_q    <= 1'b0;
            eoi_pend_q <= 1'b0;
            eoi_done_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            nxt_q      <= nxt_d;
            nxt_vld_q  <= nxt_vld_d;
            outst_q    <= outst_d;
            eoi_pend_q <= eoi_pend_d;
            eoi_done_q <= eoi_done_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ff_stuff_ctrl.sv
// Directed bench: u0 stuffs with prefetch, u1 passes bytes through without prefetch.
`timescale 1ns/1ps
module tb_ff_stuff_ctrl;

    logic        clk;
    logic        rst;
    logic [1:0]  fifo_empty, read_req, rdata_valid, out_valid, out_ready;
    logic [1:0]  eoi_req, eoi_done, busy, stray, m_rv, req_s;
    logic [31:0] read_data [2];
    logic [31:0] m_rd [2];
    logic [7:0]  out_byte [2];
    logic [23:0] byte_count [2];

    logic [31:0]  mem [2][0:31];
    int           wp [2];
    int           rp [2];
    logic [127:0] got [2];
    int           bcnt [2];
    int           edone [2];
    int           nreq [2];
    int           lastreq [2];
    int           bcyc [2][0:255];
    int           cyc;
    int           viol;
    int           checks;
    int           errors;
    logic [23:0]  exp_cnt [2];

    typedef struct {
        int          inst;
        logic [31:0] w;
        int          n;
        logic [63:0] exp;
    } vec_t;
    vec_t vt [7];

    ff_stuff_ctrl #(.STUFF_EN(1'b1), .PREFETCH(1'b1), .CNT_W(24)) u0 (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty[0]), .read_req(read_req[0]),
        .read_data(read_data[0]), .rdata_valid(rdata_valid[0]), .out_byte(out_byte[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .eoi_req(eoi_req[0]),
        .eoi_done(eoi_done[0]), .busy(busy[0]), .byte_count(byte_count[0])
    );

    ff_stuff_ctrl #(.STUFF_EN(1'b0), .PREFETCH(1'b0), .CNT_W(24)) u1 (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty[1]), .read_req(read_req[1]),
        .read_data(read_data[1]), .rdata_valid(rdata_valid[1]), .out_byte(out_byte[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .eoi_req(eoi_req[1]),
        .eoi_done(eoi_done[1]), .busy(busy[1]), .byte_count(byte_count[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    assign fifo_empty[0]  = (wp[0] == rp[0]);
    assign fifo_empty[1]  = (wp[1] == rp[1]);
    assign rdata_valid[0] = m_rv[0] | stray[0];
    assign rdata_valid[1] = m_rv[1] | stray[1];
    assign read_data[0]   = stray[0] ? 32'hDEADBEEF : m_rd[0];
    assign read_data[1]   = stray[1] ? 32'hDEADBEEF : m_rd[1];

    // FIFO model: a request seen in a cycle returns its word the following cycle.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) req_s[k] = read_req[k] && (wp[k] != rp[k]);
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            m_rv[k] <= 1'b0;
            if (req_s[k]) begin
                m_rd[k] <= mem[k][rp[k] % 32];
                m_rv[k] <= 1'b1;
                rp[k]   <= rp[k] + 1;
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (out_valid[k] && out_ready[k]) begin
                got[k] = {got[k][119:0], out_byte[k]};
                bcyc[k][bcnt[k] % 256] = cyc;
                bcnt[k] = bcnt[k] + 1;
            end
            if (eoi_done[k]) edone[k] = edone[k] + 1;
            if (read_req[k]) begin
                nreq[k] = nreq[k] + 1;
                lastreq[k] = cyc;
                if (fifo_empty[k] || m_rv[k]) viol = viol + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] got_v, input logic [127:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, got_v, exp_v);
        end
    endtask

    task automatic push(input int k, input logic [31:0] w);
        mem[k][wp[k] % 32] = w;
        wp[k] = wp[k] + 1;
    endtask

    task automatic wait_n(input int k, input int n, input int base_v, input string nm);
        for (int t = 0; t < 300 && (bcnt[k] - base_v) < n; t++) begin
            @(negedge clk);
            #1;
        end
        if ((bcnt[k] - base_v) < n) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got %0d bytes, expected %0d", nm, bcnt[k] - base_v, n);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_cnt[0] = '0;
        exp_cnt[1] = '0;
    endtask

    initial begin
        int k, base, n0, b0;
        logic [127:0] msk;

        checks = 0; errors = 0; viol = 0;
        for (int i = 0; i < 2; i++) begin
            wp[i] = 0; rp[i] = 0; got[i] = '0; bcnt[i] = 0; edone[i] = 0;
            nreq[i] = 0; lastreq[i] = 0; exp_cnt[i] = '0;
        end
        req_s = '0; m_rv = '0; stray = '0; eoi_req = '0; out_ready = '0;
        m_rd[0] = '0; m_rd[1] = '0;

        vt[0] = '{0, 32'h12345678, 4, 64'h12345678};
        vt[1] = '{0, 32'hFF00FF11, 6, 64'hFF0000FF0011};
        vt[2] = '{1, 32'hFF00FF11, 4, 64'hFF00FF11};
        vt[3] = '{0, 32'hFFFFFFFF, 8, 64'hFF00FF00FF00FF00};
        vt[4] = '{1, 32'hFFFFFFFF, 4, 64'hFFFFFFFF};
        vt[5] = '{0, 32'h00000000, 4, 64'h00000000};
        vt[6] = '{0, 32'hABCDEFFF, 5, 64'hABCDEFFF00};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_out_valid", out_valid[0], 1'b0);
        chk("rst_out_byte", out_byte[0], 8'h00);
        chk("rst_read_req", read_req[0], 1'b0);
        chk("rst_eoi_done", eoi_done[0], 1'b0);
        chk("rst_busy", busy[0], 1'b0);
        chk("rst_byte_count", byte_count[0], 24'd0);
        chk("rst_u1_out_valid", out_valid[1], 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        out_ready = 2'b11;

        // Single-word vectors on both stuffing variants.
        for (int i = 0; i < 7; i++) begin
            k = vt[i].inst;
            base = bcnt[k];
            @(posedge clk); #1 push(k, vt[i].w);
            wait_n(k, vt[i].n, base, "vec_wait");
            repeat (3) @(negedge clk);
            #1;
            exp_cnt[k] = exp_cnt[k] + 24'(vt[i].n);
            msk = {128{1'b1}} >> (128 - 8 * vt[i].n);
            chk("vec_bytes", got[k] & msk, {64'd0, vt[i].exp});
            chk("vec_nbytes", bcnt[k] - base, vt[i].n);
            chk("vec_byte_count", byte_count[k], exp_cnt[k]);
            chk("vec_busy_idle", busy[k], 1'b0);
            if (i == 0) chk("first_byte_latency", bcyc[k][base % 256] - lastreq[k], 2);
        end

        // Stall on byte 0x56: output held, only hold+next slots fetched.
        do_reset();
        out_ready[0] = 1'b0;
        n0 = nreq[0];
        base = bcnt[0];
        push(0, 32'h12345678);
        push(0, 32'h9ABCDEF0);
        push(0, 32'h11111111);
        for (int t = 0; t < 20 && !out_valid[0]; t++) @(negedge clk);
        @(posedge clk); #1 out_ready[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1 out_ready[0] = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk); #1;
            chk("stall_valid", out_valid[0], 1'b1);
            chk("stall_byte", out_byte[0], 8'h56);
        end
        chk("stall_reads", nreq[0] - n0, 2);
        chk("stall_fifo_left", wp[0] - rp[0], 1);
        @(posedge clk); #1 out_ready[0] = 1'b1;
        wait_n(0, 12, base, "stall_drain");
        repeat (3) @(negedge clk);
        #1;
        chk("stall_seq", got[0] & {32'd0, {96{1'b1}}}, 128'h123456789ABCDEF011111111);
        chk("stall_nbytes", bcnt[0] - base, 12);

        // Four queued words stream back to back.
        do_reset();
        base = bcnt[0];
        push(0, 32'h01020304);
        push(0, 32'h05060708);
        push(0, 32'h090A0B0C);
        push(0, 32'h0D0E0F10);
        wait_n(0, 16, base, "b2b_wait");
        repeat (3) @(negedge clk);
        #1;
        chk("b2b_seq", got[0], 128'h0102030405060708090A0B0C0D0E0F10);
        chk("b2b_span", bcyc[0][(base + 15) % 256] - bcyc[0][base % 256], 15);
        chk("b2b_byte_count", byte_count[0], 24'd16);

        // Without prefetch there are two idle cycles between words.
        base = bcnt[1];
        @(posedge clk); #1;
        push(1, 32'h01020304);
        push(1, 32'h05060708);
        wait_n(1, 8, base, "gap_wait");
        repeat (3) @(negedge clk);
        #1;
        chk("gap_seq", got[1] & {64'd0, {64{1'b1}}}, 128'h0102030405060708);
        chk("gap_cycles", bcyc[1][(base + 4) % 256] - bcyc[1][(base + 3) % 256], 3);

        // EOI after two words, with a duplicate request while pending.
        do_reset();
        base = bcnt[0];
        b0 = edone[0];
        push(0, 32'h11223344);
        push(0, 32'h55667788);
        eoi_req[0] = 1'b1;
        @(posedge clk); #1 eoi_req[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 eoi_req[0] = 1'b1;
        @(posedge clk); #1 eoi_req[0] = 1'b0;
        wait_n(0, 10, base, "eoi_wait");
        repeat (10) @(negedge clk);
        #1;
        chk("eoi_seq", got[0] & {48'd0, {80{1'b1}}}, 128'h1122334455667788FFD9);
        chk("eoi_nbytes", bcnt[0] - base, 10);
        chk("eoi_done_pulses", edone[0] - b0, 1);
        chk("eoi_byte_count", byte_count[0], 24'd10);

        // Read data with no read outstanding is dropped.
        base = bcnt[0];
        @(posedge clk); #1 stray[0] = 1'b1;
        @(posedge clk); #1 stray[0] = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("stray_nbytes", bcnt[0] - base, 0);
        chk("stray_busy", busy[0], 1'b0);
        chk("stray_byte_count", byte_count[0], 24'd10);

        // Reset while byte index 2 is on the output.
        push(0, 32'h12345678);
        push(0, 32'h9ABCDEF0);
        push(0, 32'h0BADF00D);
        for (int t = 0; t < 20 && !(out_valid[0] && out_byte[0] == 8'h56); t++) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        chk("midrst_out_valid", out_valid[0], 1'b0);
        chk("midrst_read_req", read_req[0], 1'b0);
        chk("midrst_byte_count", byte_count[0], 24'd0);
        chk("midrst_busy", busy[0], 1'b0);
        chk("midrst_fifo_nonempty", fifo_empty[0], 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk); #1;

        chk("read_req_rule_violations", viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
